// File: rtl/jb_power_down_seq_if.sv
// rtl/jb_power_down_seq_if.sv - alarm, control and shutdown-output bundle for the power-down sequencer
interface jb_power_down_seq_if #(
   parameter int NUM_ALARMS  = 4,
   parameter int DEBOUNCE_BW = 8,
   parameter int DELAY_BW    = 16
);
   logic [NUM_ALARMS-1:0]  alarm_n;
   logic [NUM_ALARMS-1:0]  alarm_enable;
   logic [DEBOUNCE_BW-1:0] debounce_cnt;
   logic [DELAY_BW-1:0]    dac_delay;
   logic [DELAY_BW-1:0]    pa_delay;
   logic                   auto_recover;
   logic                   clear;
   logic                   force_shutdown;
   logic                   psu_shutdown;
   logic                   dac_shutdown;
   logic                   pa_shutdown;
   logic [NUM_ALARMS-1:0]  alarm_latched;
   logic [1:0]             seq_state;

   modport master (
      output alarm_n, alarm_enable, debounce_cnt, dac_delay, pa_delay,
             auto_recover, clear, force_shutdown,
      input  psu_shutdown, dac_shutdown, pa_shutdown, alarm_latched, seq_state
   );

   modport slave (
      input  alarm_n, alarm_enable, debounce_cnt, dac_delay, pa_delay,
             auto_recover, clear, force_shutdown,
      output psu_shutdown, dac_shutdown, pa_shutdown, alarm_latched, seq_state
   );
endinterface

// File: rtl/jb_power_down_seq.sv
// rtl/jb_power_down_seq.sv - multi-alarm debounced power-fail shutdown sequencer (PSU, then DAC, then PA)
module jb_power_down_seq #(
   parameter int NUM_ALARMS  = 4,
   parameter int DEBOUNCE_BW = 8,
   parameter int DELAY_BW    = 16
) (
   input  logic               clk_15p36,
   input  logic               reset_15p36,
   jb_power_down_seq_if.slave pd
);
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_TRIP     = 2'd1,
      ST_DAC_OFF  = 2'd2,
      ST_SHUTDOWN = 2'd3
   } state_t;

   logic [NUM_ALARMS-1:0]  sync1_q, sync1_d;
   logic [NUM_ALARMS-1:0]  sync2_q, sync2_d;
   logic [DEBOUNCE_BW-1:0] cnt_q [NUM_ALARMS];
   logic [DEBOUNCE_BW-1:0] cnt_d [NUM_ALARMS];
   logic [NUM_ALARMS-1:0]  latch_q, latch_d;
   logic [NUM_ALARMS-1:0]  qual;
   logic [DEBOUNCE_BW-1:0] deb_min;
   logic [DELAY_BW-1:0]    dac_min, pa_min;
   logic                   trip;

   state_t                 state_q, state_d;
   logic [DELAY_BW-1:0]    dly_cnt_q, dly_cnt_d;
   logic [DELAY_BW-1:0]    dly_lim_q, dly_lim_d;
   logic                   psu_q, psu_d;
   logic                   dac_q, dac_d;
   logic                   pa_q, pa_d;

   // Zero programmed thresholds/delays behave as one cycle.
   assign deb_min = (pd.debounce_cnt == '0) ? DEBOUNCE_BW'(1) : pd.debounce_cnt;
   assign dac_min = (pd.dac_delay == '0) ? DELAY_BW'(1) : pd.dac_delay;
   assign pa_min  = (pd.pa_delay == '0) ? DELAY_BW'(1) : pd.pa_delay;

   always_comb begin
      sync1_d = pd.alarm_n;
      sync2_d = sync1_q;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         cnt_d[i] = '0;
         if (!sync2_q[i] && pd.alarm_enable[i]) begin
            cnt_d[i] = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + DEBOUNCE_BW'(1);
         end
         qual[i] = (cnt_q[i] >= deb_min);
      end
      trip    = (|qual) | pd.force_shutdown;
      // A still-qualified channel keeps its bit even under clear.
      latch_d = qual | (latch_q & ~{NUM_ALARMS{pd.clear}});
   end

   always_comb begin
      state_d   = state_q;
      dly_cnt_d = dly_cnt_q + DELAY_BW'(1);
      dly_lim_d = dly_lim_q;
      case (state_q)
         ST_IDLE: begin
            dly_cnt_d = '0;
            if (trip) begin
               state_d   = ST_TRIP;
               dly_lim_d = dac_min;
            end
         end
         ST_TRIP: begin
            if (dly_cnt_q == dly_lim_q - DELAY_BW'(1)) begin
               state_d   = ST_DAC_OFF;
               dly_cnt_d = '0;
               dly_lim_d = pa_min;
            end
         end
         ST_DAC_OFF: begin
            if (dly_cnt_q == dly_lim_q - DELAY_BW'(1)) begin
               state_d   = ST_SHUTDOWN;
               dly_cnt_d = '0;
            end
         end
         ST_SHUTDOWN: begin
            dly_cnt_d = '0;
            if (!trip && (pd.auto_recover || pd.clear)) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            dly_cnt_d = '0;
         end
      endcase
      psu_d = (state_d != ST_IDLE);
      dac_d = (state_d == ST_DAC_OFF) || (state_d == ST_SHUTDOWN);
      pa_d  = (state_d == ST_SHUTDOWN);
   end

   always_ff @(posedge clk_15p36 or posedge reset_15p36) begin
      if (reset_15p36) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         latch_q   <= '0;
         state_q   <= ST_IDLE;
         dly_cnt_q <= '0;
         dly_lim_q <= '0;
         psu_q     <= 1'b0;
         dac_q     <= 1'b0;
         pa_q      <= 1'b0;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         latch_q   <= latch_d;
         state_q   <= state_d;
         dly_cnt_q <= dly_cnt_d;
         dly_lim_q <= dly_lim_d;
         psu_q     <= psu_d;
         dac_q     <= dac_d;
         pa_q      <= pa_d;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign pd.psu_shutdown  = psu_q;
   assign pd.dac_shutdown  = dac_q;
   assign pd.pa_shutdown   = pa_q;
   assign pd.alarm_latched = latch_q;
   assign pd.seq_state     = state_q;
endmodule

// File: tb/tb_jb_power_down_seq.sv
// tb/tb_jb_power_down_seq.sv - scoreboard bench: expected state transitions queued at stimulus time
module tb_jb_power_down_seq;
   localparam int NA = 4;

   typedef struct {
      logic [1:0] st;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb_q[$];
   logic [1:0] prev_st = 2'd0;

   jb_power_down_seq_if #(.NUM_ALARMS(NA), .DEBOUNCE_BW(8), .DELAY_BW(16)) pd_if ();

   jb_power_down_seq #(.NUM_ALARMS(NA), .DEBOUNCE_BW(8), .DELAY_BW(16)) dut (
      .clk_15p36   (clk),
      .reset_15p36 (rst),
      .pd          (pd_if.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push(input logic [1:0] st, input int at);
      exp_t e;
      e.st  = st;
      e.cyc = at;
      sb_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic pulse_clear();
      pd_if.clear = 1'b1;
      step(1);
      pd_if.clear = 1'b0;
   endtask

   // Every observed state change must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         prev_st = pd_if.seq_state;
      end else if (pd_if.seq_state !== prev_st) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_transition", {30'd0, pd_if.seq_state}, {30'd0, prev_st});
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("seq_state", {30'd0, pd_if.seq_state}, {30'd0, e.st});
            chk("edge", cyc, e.cyc);
            chk("psu_shutdown", {31'd0, pd_if.psu_shutdown}, {31'd0, e.st != 2'd0});
            chk("dac_shutdown", {31'd0, pd_if.dac_shutdown}, {31'd0, e.st >= 2'd2});
            chk("pa_shutdown", {31'd0, pd_if.pa_shutdown}, {31'd0, e.st == 2'd3});
         end
         prev_st = pd_if.seq_state;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c, e, q, r;
      pd_if.alarm_n        = 4'hF;
      pd_if.alarm_enable   = 4'hF;
      pd_if.debounce_cnt   = 8'd4;
      pd_if.dac_delay      = 16'd10;
      pd_if.pa_delay       = 16'd5;
      pd_if.auto_recover   = 1'b1;
      pd_if.clear          = 1'b0;
      pd_if.force_shutdown = 1'b0;
      step(3);
      rst = 1'b0;
      step(1);
      chk("rst_state", {30'd0, pd_if.seq_state}, 32'd0);
      chk("rst_psu", {31'd0, pd_if.psu_shutdown}, 32'd0);
      chk("rst_dac", {31'd0, pd_if.dac_shutdown}, 32'd0);
      chk("rst_pa", {31'd0, pd_if.pa_shutdown}, 32'd0);
      chk("rst_latched", {28'd0, pd_if.alarm_latched}, 32'd0);

      // Debounce: 3-cycle glitch rejected, sustained low trips 6 edges after first sample.
      pd_if.alarm_n = 4'b1101;
      step(3);
      pd_if.alarm_n = 4'hF;
      step(10);
      chk("glitch_state", {30'd0, pd_if.seq_state}, 32'd0);
      chk("glitch_latched", {28'd0, pd_if.alarm_latched}, 32'd0);
      c = cyc;
      pd_if.alarm_n = 4'b1101;
      push(2'd1, c + 7);
      push(2'd2, c + 17);
      push(2'd3, c + 22);
      wait_cyc(c + 7);
      chk("deb_latched", {28'd0, pd_if.alarm_latched}, 32'h2);
      wait_cyc(c + 23);
      chk("seq_shutdown", {30'd0, pd_if.seq_state}, 32'd3);
      r = cyc;
      pd_if.alarm_n = 4'hF;
      push(2'd0, r + 4);
      wait_cyc(r + 6);
      chk("sticky_latched", {28'd0, pd_if.alarm_latched}, 32'h2);
      pulse_clear();
      step(1);
      chk("cleared_latched", {28'd0, pd_if.alarm_latched}, 32'd0);

      // Zero delays, manual recovery, re-trip right after recovery.
      pd_if.dac_delay    = 16'd0;
      pd_if.pa_delay     = 16'd0;
      pd_if.auto_recover = 1'b0;
      c = cyc;
      pd_if.force_shutdown = 1'b1;
      push(2'd1, c + 1);
      push(2'd2, c + 2);
      push(2'd3, c + 3);
      wait_cyc(c + 5);
      pd_if.force_shutdown = 1'b0;
      step(5);
      chk("manual_hold", {30'd0, pd_if.seq_state}, 32'd3);
      q = cyc;
      push(2'd0, q + 1);
      push(2'd1, q + 2);
      push(2'd2, q + 3);
      push(2'd3, q + 4);
      pd_if.clear = 1'b1;
      step(1);
      pd_if.clear = 1'b0;
      pd_if.force_shutdown = 1'b1;
      wait_cyc(q + 6);
      pd_if.force_shutdown = 1'b0;
      q = cyc;
      push(2'd0, q + 1);
      pulse_clear();
      step(1);
      chk("retrip_idle", {30'd0, pd_if.seq_state}, 32'd0);

      // Masking, enable trips after debounce+1 edges, mid-stage delay change ignored.
      pd_if.debounce_cnt = 8'd2;
      pd_if.dac_delay    = 16'd3;
      pd_if.pa_delay     = 16'd2;
      pd_if.alarm_enable = 4'b1011;
      pd_if.alarm_n      = 4'b1011;
      step(10);
      chk("mask_state", {30'd0, pd_if.seq_state}, 32'd0);
      chk("mask_latched", {28'd0, pd_if.alarm_latched}, 32'd0);
      e = cyc;
      pd_if.alarm_enable = 4'hF;
      push(2'd1, e + 3);
      push(2'd2, e + 6);
      push(2'd3, e + 8);
      wait_cyc(e + 4);
      pd_if.dac_delay = 16'd50;
      wait_cyc(e + 10);
      pulse_clear();
      step(1);
      chk("clear_while_qual_state", {30'd0, pd_if.seq_state}, 32'd3);
      chk("clear_while_qual_latched", {28'd0, pd_if.alarm_latched}, 32'h4);
      pd_if.alarm_n = 4'hF;
      step(6);
      chk("manual_hold2", {30'd0, pd_if.seq_state}, 32'd3);
      q = cyc;
      push(2'd0, q + 1);
      pulse_clear();
      step(1);
      chk("manual_clear_latched", {28'd0, pd_if.alarm_latched}, 32'd0);

      // Abort immunity: release and clear during TRIP.
      pd_if.auto_recover = 1'b1;
      pd_if.debounce_cnt = 8'd1;
      pd_if.dac_delay    = 16'd4;
      pd_if.pa_delay     = 16'd3;
      c = cyc;
      pd_if.alarm_n = 4'b1110;
      push(2'd1, c + 4);
      push(2'd2, c + 8);
      push(2'd3, c + 11);
      push(2'd0, c + 12);
      wait_cyc(c + 4);
      pd_if.alarm_n = 4'hF;
      pulse_clear();
      chk("abort_latched_kept", {28'd0, pd_if.alarm_latched}, 32'h1);
      wait_cyc(c + 13);
      chk("abort_latched_after", {28'd0, pd_if.alarm_latched}, 32'h1);
      pulse_clear();
      step(1);
      chk("abort_latched_cleared", {28'd0, pd_if.alarm_latched}, 32'd0);

      // Asynchronous reset while in DAC_OFF.
      pd_if.dac_delay = 16'd2;
      pd_if.pa_delay  = 16'd20;
      c = cyc;
      pd_if.alarm_n = 4'b0111;
      push(2'd1, c + 4);
      push(2'd2, c + 6);
      wait_cyc(c + 8);
      chk("pre_reset_state", {30'd0, pd_if.seq_state}, 32'd2);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_psu", {31'd0, pd_if.psu_shutdown}, 32'd0);
      chk("async_rst_dac", {31'd0, pd_if.dac_shutdown}, 32'd0);
      chk("async_rst_pa", {31'd0, pd_if.pa_shutdown}, 32'd0);
      chk("async_rst_state", {30'd0, pd_if.seq_state}, 32'd0);
      chk("async_rst_latched", {28'd0, pd_if.alarm_latched}, 32'd0);
      pd_if.alarm_n = 4'hF;
      step(3);
      rst = 1'b0;
      step(3);
      chk("post_reset_state", {30'd0, pd_if.seq_state}, 32'd0);

      chk("scoreboard_empty", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/jb_power_down_seq.md
# jb_power_down_seq

Parametrised multi-source power-fail shutdown sequencer, the next generation of the single-alarm power-down block in the PL control layer. It synchronises and debounces NUM_ALARMS active-low alarm inputs and latches which alarms fired. It runs a timed shutdown sequence (PSU flag, then DAC, then PA) with programmable inter-stage delays, and returns to normal either automatically or on software clear. It sits beside the timers under the top-level PL control module, in the 15.36 MHz domain.

## Interface
- NUM_ALARMS, 4, number of independent alarm sources (1..16)
- DEBOUNCE_BW, 8, width of debounce count
- DELAY_BW, 16, width of stage delay counts
- clk_15p36  in  1  sole clock
- reset_15p36  in  1  asynchronous, active-high reset
- alarm_n  in  NUM_ALARMS  raw alarm inputs, active-low, asynchronous to clk_15p36
- alarm_enable  in  NUM_ALARMS  per-channel enable; 0 masks the channel
- debounce_cnt  in  DEBOUNCE_BW  consecutive synchronised-low cycles required to qualify; 0 treated as 1
- dac_delay  in  DELAY_BW  cycles spent in TRIP before DAC shutdown; 0 treated as 1
- pa_delay  in  DELAY_BW  cycles spent in DAC_OFF before PA shutdown; 0 treated as 1
- auto_recover  in  1  1: leave SHUTDOWN automatically when no trip is active; 0: leave only on clear
- clear  in  1  single-cycle pulse; clears latched status and releases manual-recover SHUTDOWN
- force_shutdown  in  1  software trip, level-sensitive, not debounced
- psu_shutdown  out  1  high in every state except IDLE
- dac_shutdown  out  1  high in DAC_OFF and SHUTDOWN
- pa_shutdown  out  1  high in SHUTDOWN
- alarm_latched  out  NUM_ALARMS  sticky record of qualified channels
- seq_state  out  2  IDLE=0, TRIP=1, DAC_OFF=2, SHUTDOWN=3

## Operation
- Per channel: 2-FF synchroniser. Synchroniser flops reset to 1 (inactive).
- Debounce counter per channel: increments, saturating, while the synchronised input is low and alarm_enable=1. Clears to 0 on a synchronised high or when enable=0.
- qual[i] = (cnt[i] >= max(debounce_cnt,1)), combinational.
- trip = |qual | force_shutdown.
- alarm_latched[i] is set on any cycle with qual[i]=1. On clear it is cleared only if qual[i]=0. Set wins over simultaneous clear. Disabling a channel does not clear its latched bit.
- FSM:
  - IDLE -> TRIP when trip=1.
  - TRIP -> DAC_OFF after max(dac_delay,1) cycles in TRIP.
  - DAC_OFF -> SHUTDOWN after max(pa_delay,1) cycles in DAC_OFF.
  - SHUTDOWN -> IDLE when trip=0 and either auto_recover=1, or auto_recover=0 with clear=1 on that cycle.
- A single shared delay counter is cleared on each state entry. The active delay value is captured on entry to TRIP or DAC_OFF. Changing dac_delay or pa_delay mid-stage has no effect on that stage.
- Once started, the sequence always completes to SHUTDOWN: alarm removal or clear in TRIP/DAC_OFF does not abort it. Clear in those states affects only alarm_latched.
- Outputs are registered flops, decoded from next state. They change on the same edge as seq_state.

## Timing
- Reset values: all outputs 0, seq_state=IDLE, counters 0, alarm_latched 0.
- Asserting reset_15p36 mid-sequence drops all shutdown outputs immediately (asynchronously). After release the block is in IDLE.
- Alarm latency: alarm_n first sampled low at edge k, held low, with debounce_cnt=N≥1. Then psu_shutdown, seq_state=TRIP and alarm_latched[i] assert at edge k+N+2.
- force_shutdown latency: high before edge k gives TRIP at edge k.
- dac_shutdown asserts max(dac_delay,1) edges after TRIP entry. pa_shutdown asserts max(pa_delay,1) edges after DAC_OFF entry.
- Glitch rejection: a low pulse shorter than N synchronised cycles never qualifies and leaves alarm_latched unchanged.
- Recovery: all three shutdown outputs deassert together on the SHUTDOWN->IDLE edge.
- Re-trip: if trip=1 in IDLE on the edge right after recovery, TRIP is re-entered one edge later.

## Test plan
- Debounce: debounce_cnt=4, alarm_n[1] low for 3 cycles, then low sustained -> no latch for the 3-cycle pulse. For the sustained low, TRIP occurs 6 edges after first low sample and alarm_latched=4'b0010.
- Sequence: dac_delay=10, pa_delay=5 -> dac_shutdown exactly 10 edges after psu_shutdown, pa_shutdown 5 edges later. Zero delays give 1-cycle stages.
- Masking: alarm_enable[2]=0 with alarm_n[2] held low -> stays IDLE, alarm_latched=0. Enabling it trips after debounce_cnt+1 edges.
- Recovery modes: auto_recover=1, alarm released in SHUTDOWN -> IDLE after debounce counter clears. auto_recover=0 -> SHUTDOWN held until a clear pulse, then IDLE next edge. Clear while the alarm is still qualified is ignored.
- Abort immunity: alarm released and clear pulsed during TRIP -> sequence still reaches SHUTDOWN. alarm_latched bit is retained while qual was high at clear, and is cleared by a later clear.
- Reset mid-DAC_OFF: assert reset_15p36 -> psu/dac/pa_shutdown go 0 without a clock edge, seq_state=0, alarm_latched=0.
